// File: rtl/avl_accum_pkg.sv
// Shared register map, STATUS bit positions and key debounce state encoding
// for the Avalon-MM switch accumulator slave.
package avl_accum_pkg;

  localparam logic [1:0] ADDR_SW     = 2'd0;
  localparam logic [1:0] ADDR_ACC    = 2'd1;
  localparam logic [1:0] ADDR_LED    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_PEND   = 0;
  localparam int STAT_OVF    = 1;
  localparam int STAT_LEDSRC = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debounce FSM for one active-low key; emits a
// single-cycle press pulse per accepted press.
module key_debounce
  import avl_accum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0, sync_p1;
  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Sync flops reset to the released level so a reset never fakes a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (!sync_p1) begin
          state_nxt = ARM_PRESS;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ARM_PRESS: begin
        if (sync_p1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (sync_p1) begin
          state_nxt = ARM_RELEASE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ARM_RELEASE: begin
        if (!sync_p1) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/avl_accum_slave.sv
// Avalon-MM slave that accumulates the switch value on debounced key presses
// and exposes SW/ACC/LEDREG/STATUS registers with one-cycle read latency.
module avl_accum_slave
  import avl_accum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [1:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic        AVL_READDATAVALID,
  input  logic [7:0]  SW,
  input  logic        KEY_ACCUM_N,
  input  logic        KEY_CLEAR_N,
  output logic [7:0]  LED
);

  function automatic logic [8:0] add_carry(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [7:0]  sw_p0, sw_p1;
  logic        acc_pulse, clr_pulse;
  logic [7:0]  acc, ledreg, led_p1;
  logic        pend, ovf, ledsrc;
  logic        wr_en, rd_en, wr_acc, wr_led, wr_status;
  logic        pend_set, ovf_set;
  logic [8:0]  sum;
  logic [31:0] status_word, rd_mux, rdata_p1;
  logic        vld_p1;
  logic        unused_wdata_hi;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_accum (
    .clk(CLK), .rst(RESET), .key_n(KEY_ACCUM_N), .press(acc_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk(CLK), .rst(RESET), .key_n(KEY_CLEAR_N), .press(clr_pulse)
  );

  // A simultaneous read+write is treated purely as a write.
  assign wr_en     = AVL_CS & AVL_WRITE;
  assign rd_en     = AVL_CS & AVL_READ & ~AVL_WRITE;
  assign wr_acc    = wr_en & (AVL_ADDR == ADDR_ACC);
  assign wr_led    = wr_en & (AVL_ADDR == ADDR_LED);
  assign wr_status = wr_en & (AVL_ADDR == ADDR_STATUS);

  assign sum      = add_carry(acc, sw_p1);
  assign pend_set = acc_pulse | clr_pulse;
  assign ovf_set  = acc_pulse & ~clr_pulse & sum[8];

  assign unused_wdata_hi = ^AVL_WRITEDATA[31:8];

  always_comb begin
    status_word              = '0;
    status_word[STAT_PEND]   = pend;
    status_word[STAT_OVF]    = ovf;
    status_word[STAT_LEDSRC] = ledsrc;
    rd_mux                   = '0;
    case (AVL_ADDR)
      ADDR_SW:  rd_mux = {24'b0, sw_p1};
      ADDR_ACC: rd_mux = {24'b0, acc};
      ADDR_LED: rd_mux = {24'b0, ledreg};
      default:  rd_mux = status_word;
    endcase
  end

  // Stage p1: synchronized switches, register updates, registered LED and read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      acc      <= '0;
      ledreg   <= '0;
      pend     <= 1'b0;
      ovf      <= 1'b0;
      ledsrc   <= 1'b0;
      led_p1   <= '0;
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      sw_p0 <= SW;
      sw_p1 <= sw_p0;
      if (wr_acc)         acc <= AVL_WRITEDATA[7:0];
      else if (clr_pulse) acc <= '0;
      else if (acc_pulse) acc <= sum[7:0];
      if (wr_led) ledreg <= AVL_WRITEDATA[7:0];
      // Hardware set beats a W1C of the same bit.
      pend <= pend_set | (pend & ~(wr_status & AVL_WRITEDATA[STAT_PEND]));
      ovf  <= ovf_set  | (ovf  & ~(wr_status & AVL_WRITEDATA[STAT_OVF]));
      if (wr_status) ledsrc <= AVL_WRITEDATA[STAT_LEDSRC];
      led_p1   <= ledsrc ? acc : ledreg;
      vld_p1   <= rd_en;
      rdata_p1 <= rd_en ? rd_mux : '0;
    end
  end

  assign LED               = led_p1;
  assign AVL_READDATA      = rdata_p1;
  assign AVL_READDATAVALID = vld_p1;

endmodule

// File: tb/tb_avl_accum_slave.sv
// Self-checking bench for avl_accum_slave with a cycle-level behavioural
// model built from run-length debounce rules and register semantics.
module tb_avl_accum_slave;

  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [1:0]  AVL_ADDR = 2'd0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic        AVL_READDATAVALID;
  logic [7:0]  SW = 8'd0;
  logic        KEY_ACCUM_N = 1'b1, KEY_CLEAR_N = 1'b1;
  logic [7:0]  LED;

  int n_tests = 0;
  int n_fail  = 0;

  avl_accum_slave #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
    .SW(SW), .KEY_ACCUM_N(KEY_ACCUM_N), .KEY_CLEAR_N(KEY_CLEAR_N), .LED(LED)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [7:0]  m_acc, m_led, m_ledout, m_sw1, m_sw2;
  logic        m_pend, m_ovf, m_src, m_rvld;
  logic [31:0] m_rdata;
  logic        m_k1 [2];
  logic        m_k2 [2];
  int          lo_run [2];
  int          hi_run [2];
  bit          pressed [2];

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_sw2};
      2'd1:    return {24'b0, m_acc};
      2'd2:    return {24'b0, m_led};
      default: return {29'b0, m_src, m_ovf, m_pend};
    endcase
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [8:0]  sum;
    logic [7:0]  n_acc;
    logic        n_pend, n_ovf, wr, rd;
    logic [1:0]  pulse;
    logic [31:0] rv;
    if (RESET) begin
      m_acc = 0; m_led = 0; m_ledout = 0; m_sw1 = 0; m_sw2 = 0;
      m_pend = 0; m_ovf = 0; m_src = 0; m_rvld = 0; m_rdata = 0;
      for (int k = 0; k < 2; k++) begin
        m_k1[k] = 1'b1; m_k2[k] = 1'b1;
        lo_run[k] = 0; hi_run[k] = 0; pressed[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      pulse[k] = 1'b0;
      if (m_k2[k] == 1'b0) begin lo_run[k]++; hi_run[k] = 0; end
      else begin hi_run[k]++; lo_run[k] = 0; end
      if (!pressed[k] && lo_run[k] >= N) begin pulse[k] = 1'b1; pressed[k] = 1; end
      else if (pressed[k] && hi_run[k] >= N) pressed[k] = 0;
    end
    wr = AVL_CS && AVL_WRITE;
    rd = AVL_CS && AVL_READ && !AVL_WRITE;
    rv = rd ? model_reg(AVL_ADDR) : 32'd0;
    sum = {1'b0, m_acc} + {1'b0, m_sw2};
    n_acc = m_acc;
    if (wr && AVL_ADDR == 2'd1) n_acc = AVL_WRITEDATA[7:0];
    else if (pulse[1])          n_acc = 8'd0;
    else if (pulse[0])          n_acc = sum[7:0];
    if (pulse[0] || pulse[1])                        n_pend = 1'b1;
    else if (wr && AVL_ADDR == 2'd3 && AVL_WRITEDATA[0]) n_pend = 1'b0;
    else                                             n_pend = m_pend;
    if (pulse[0] && !pulse[1] && sum[8])             n_ovf = 1'b1;
    else if (wr && AVL_ADDR == 2'd3 && AVL_WRITEDATA[1]) n_ovf = 1'b0;
    else                                             n_ovf = m_ovf;
    m_ledout = m_src ? m_acc : m_led;
    m_rdata  = rv;
    m_rvld   = rd;
    if (wr && AVL_ADDR == 2'd2) m_led = AVL_WRITEDATA[7:0];
    if (wr && AVL_ADDR == 2'd3) m_src = AVL_WRITEDATA[2];
    m_acc  = n_acc;
    m_pend = n_pend;
    m_ovf  = n_ovf;
    m_sw2 = m_sw1; m_sw1 = SW;
    m_k2[0] = m_k1[0]; m_k1[0] = KEY_ACCUM_N;
    m_k2[1] = m_k1[1]; m_k1[1] = KEY_CLEAR_N;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
  endtask

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    AVL_CS = 1; AVL_WRITE = 1; AVL_READ = 0; AVL_ADDR = a; AVL_WRITEDATA = d;
    tick();
    bus_idle();
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = a;
    tick();
    d = AVL_READDATA;
    v = AVL_READDATAVALID;
    bus_idle();
  endtask

  task automatic press_key(input int which, input int hold);
    if (which == 0) KEY_ACCUM_N = 0; else KEY_CLEAR_N = 0;
    repeat (hold) tick();
    KEY_ACCUM_N = 1; KEY_CLEAR_N = 1;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    RESET = 1; AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 2'd1;
    tick(); tick();
    n_tests++; if (AVL_READDATAVALID !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", AVL_READDATAVALID); end
    n_tests++; if (AVL_READDATA !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", AVL_READDATA); end
    n_tests++; if (LED !== 8'd0) begin n_fail++; $display("FAIL reset_led: got %h want 0", LED); end
    bus_idle(); RESET = 0; tick();
    avl_read(2'd1, d, v);
    n_tests++; if (v !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL reset_acc: got v=%b d=%h want v=1 d=0", v, d); end
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_accum_wrap();
    logic [31:0] d; logic v;
    SW = 8'h30;
    repeat (3) press_key(0, 10);
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h90) begin n_fail++; $display("FAIL wrap_acc3: got %h want 90", d); end
    avl_read(2'd3, d, v);
    n_tests++; if (d[1:0] !== 2'b01) begin n_fail++; $display("FAIL wrap_status3: got %h want ovf=0 pend=1", d); end
    avl_write(2'd3, 32'h3);
    SW = 8'h80;
    press_key(0, 10);
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h10) begin n_fail++; $display("FAIL wrap_acc4: got %h want 10", d); end
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL wrap_status4: got %h want 3", d); end
  endtask

  task automatic test_debounce();
    logic [31:0] d; logic v;
    int lv [6] = '{0, 1, 0, 1, 0, 1};
    int len [6] = '{3, 1, 2, 1, 20, 10};
    avl_write(2'd1, 32'h0);
    SW = 8'h05;
    for (int i = 0; i < 6; i++) begin
      KEY_ACCUM_N = lv[i][0];
      repeat (len[i]) tick();
    end
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h05) begin n_fail++; $display("FAIL debounce_acc: got %h want 05", d); end
    n_tests++; if (d !== {24'b0, m_acc}) begin n_fail++; $display("FAIL debounce_model: got %h model %h", d, m_acc); end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; logic v;
    logic [31:0] obs_d [5];
    logic        obs_v [5];
    logic [31:0] exp_d [5] = '{32'h11, 32'h22, 32'h4, 32'h0, 32'h0};
    logic        exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    avl_write(2'd1, 32'h11);
    avl_write(2'd2, 32'h22);
    avl_write(2'd3, 32'h7);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 2'(i + 1); end
      else bus_idle();
      tick();
      obs_d[i] = AVL_READDATA; obs_v[i] = AVL_READDATAVALID;
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (obs_v[i] !== exp_v[i] || obs_d[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL rdlat_%0d: got v=%b d=%h want v=%b d=%h", i, obs_v[i], obs_d[i], exp_v[i], exp_d[i]);
      end
    end
    n_tests++; if (LED !== 8'h11) begin n_fail++; $display("FAIL rdlat_led: got %h want 11", LED); end
    avl_write(2'd0, 32'hFF);
    avl_read(2'd0, d, v);
    n_tests++; if (d !== 32'h05) begin n_fail++; $display("FAIL sw_reg: got %h want 05", d); end
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 1; AVL_ADDR = 2'd1; AVL_WRITEDATA = 32'h33;
    tick();
    bus_idle();
    n_tests++; if (AVL_READDATAVALID !== 1'b0 || AVL_READDATA !== 32'd0) begin
      n_fail++; $display("FAIL rdwr_vld: got v=%b d=%h want v=0 d=0", AVL_READDATAVALID, AVL_READDATA); end
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h33) begin n_fail++; $display("FAIL rdwr_acc: got %h want 33", d); end
  endtask

  task automatic test_led_src();
    avl_write(2'd3, 32'h0);
    avl_write(2'd2, 32'hA5);
    tick();
    n_tests++; if (LED !== 8'hA5) begin n_fail++; $display("FAIL led_reg: got %h want a5", LED); end
    avl_write(2'd1, 32'h3C);
    avl_write(2'd3, 32'h4);
    n_tests++; if (LED !== 8'hA5) begin n_fail++; $display("FAIL led_switch_early: got %h want a5", LED); end
    tick();
    n_tests++; if (LED !== 8'h3C) begin n_fail++; $display("FAIL led_acc: got %h want 3c", LED); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic v;
    avl_write(2'd3, 32'h3);
    avl_write(2'd1, 32'h20);
    SW = 8'hF0;
    repeat (3) tick();
    KEY_ACCUM_N = 0;
    repeat (5) tick();
    avl_write(2'd1, 32'h55);
    KEY_ACCUM_N = 1;
    repeat (10) tick();
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h55) begin n_fail++; $display("FAIL coll_acc: got %h want 55", d); end
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL coll_status: got %h want 3", d); end
    avl_write(2'd3, 32'h3);
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", d); end
    KEY_ACCUM_N = 0;
    repeat (5) tick();
    avl_write(2'd3, 32'h1);
    KEY_ACCUM_N = 1;
    repeat (10) tick();
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_coll_status: got %h want 3", d); end
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h45) begin n_fail++; $display("FAIL w1c_coll_acc: got %h want 45", d); end
    avl_write(2'd3, 32'h3);
    KEY_ACCUM_N = 0; KEY_CLEAR_N = 0;
    repeat (10) tick();
    KEY_ACCUM_N = 1; KEY_CLEAR_N = 1;
    repeat (10) tick();
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL clr_wins_acc: got %h want 0", d); end
    avl_read(2'd3, d, v);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL clr_wins_status: got %h want 1", d); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] d; logic v;
    SW = 8'h07;
    avl_write(2'd1, 32'h0);
    KEY_ACCUM_N = 0;
    repeat (4) tick();
    RESET = 1;
    tick();
    RESET = 0;
    n_tests++; if (LED !== 8'h0 || AVL_READDATAVALID !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got led=%h v=%b want 0 0", LED, AVL_READDATAVALID); end
    for (int k = 1; k <= 10; k++) begin
      AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 2'd1;
      tick();
      n_tests++;
      if (AVL_READDATA !== m_rdata || (k <= N && AVL_READDATA !== 32'd0)) begin
        n_fail++; $display("FAIL midrst_acc_%0d: got %h model %h", k, AVL_READDATA, m_rdata);
      end
    end
    bus_idle();
    KEY_ACCUM_N = 1;
    repeat (10) tick();
    avl_read(2'd1, d, v);
    n_tests++; if (d !== 32'h07) begin n_fail++; $display("FAIL midrst_final: got %h want 07", d); end
  endtask

  task automatic test_random();
    int op;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) SW = 8'($urandom);
      if ($urandom_range(0, 9) == 0) KEY_ACCUM_N = ~KEY_ACCUM_N;
      if ($urandom_range(0, 19) == 0) KEY_CLEAR_N = ~KEY_CLEAR_N;
      op = $urandom_range(0, 7);
      AVL_CS = (op != 0); AVL_READ = (op >= 1 && op <= 4) || op == 7;
      AVL_WRITE = (op >= 5); AVL_ADDR = 2'($urandom);
      AVL_WRITEDATA = $urandom;
      tick();
      n_tests++; if (AVL_READDATAVALID !== m_rvld) begin n_fail++; $display("FAIL rnd_vld_%0d: got %b model %b", c, AVL_READDATAVALID, m_rvld); end
      n_tests++; if (AVL_READDATA !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata_%0d: got %h model %h", c, AVL_READDATA, m_rdata); end
      n_tests++; if (LED !== m_ledout) begin n_fail++; $display("FAIL rnd_led_%0d: got %h model %h", c, LED, m_ledout); end
    end
    bus_idle();
    KEY_ACCUM_N = 1; KEY_CLEAR_N = 1;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_accum_wrap();
    test_debounce();
    test_read_latency();
    test_led_src();
    test_collision();
    test_reset_mid_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_accum_slave.md
AVL_ACCUM_SLAVE -- requirements
Module: avl_accum_slave

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning key-stable cycles required before a press is accepted (10 ms at 50 MHz).
REQ-002 SHALL have port CLK, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port AVL_CS, input, 1, meaning Avalon-MM chip select.
REQ-005 SHALL have port AVL_READ, input, 1, meaning read strobe, qualified by AVL_CS.
REQ-006 SHALL have port AVL_WRITE, input, 1, meaning write strobe, qualified by AVL_CS.
REQ-007 SHALL have port AVL_ADDR, input, 2, meaning word address of the register.
REQ-008 SHALL have port AVL_WRITEDATA, input, 32, meaning write data.
REQ-009 SHALL have port AVL_READDATA, output, 32, meaning read data.
REQ-010 SHALL have port AVL_READDATAVALID, output, 1, meaning AVL_READDATA is valid this cycle.
REQ-011 SHALL have port SW, input, 8, meaning asynchronous switch inputs.
REQ-012 SHALL have port KEY_ACCUM_N, input, 1, meaning asynchronous active-low accumulate key.
REQ-013 SHALL have port KEY_CLEAR_N, input, 1, meaning asynchronous active-low clear key.
REQ-014 SHALL have port LED, output, 8, meaning LED drive.

Function
REQ-015 SHALL synchronize SW, KEY_ACCUM_N and KEY_CLEAR_N through 2 flops each before any use.
REQ-016 SHALL, per key, run an FSM with states IDLE, ARM_PRESS, HELD and ARM_RELEASE, using a counter reset on every input change.
REQ-017 SHALL move IDLE->ARM_PRESS on a synchronized low; ARM_PRESS->HELD after DEBOUNCE_CYCLES consecutive low cycles, emitting a 1-cycle press pulse; ARM_PRESS->IDLE on any high.
REQ-018 SHALL move HELD->ARM_RELEASE on a high; ARM_RELEASE->IDLE after DEBOUNCE_CYCLES consecutive high cycles; ARM_RELEASE->HELD on any low, with no new pulse.
REQ-019 SHALL emit exactly one press pulse per debounced press, however long the key is held.
REQ-020 SHALL, on an accumulate pulse, compute ACC <= ACC + SW_sync modulo 256, set STATUS.OVF on carry-out, and set STATUS.PEND.
REQ-021 SHALL, on a clear pulse, set ACC <= 0; a clear wins over a same-cycle accumulate, and PEND is still set.
REQ-022 SHALL use this register map:
  - 0 SW: RO, {24'b0, SW_sync}.
  - 1 ACC: RW, bits 7:0.
  - 2 LEDREG: RW, bits 7:0.
  - 3 STATUS: bit0 PEND (W1C), bit1 OVF (W1C), bit2 LEDSRC (RW).
REQ-023 SHALL drive LED = ACC when LEDSRC=1, else LEDREG, registered, with 1-cycle latency.
REQ-024 SHALL accept a write in the cycle AVL_CS&AVL_WRITE with no wait states; writes to address 0 are ignored.
REQ-025 SHALL give an Avalon ACC write priority over a same-cycle key accumulate or clear to ACC; OVF/PEND updates from the key event still occur.
REQ-026 SHALL let a same-cycle hardware set of PEND or OVF win over a W1C write of that bit.
REQ-027 SHALL, for a read in cycle N, assert AVL_READDATAVALID for exactly cycle N+1, with register contents as of cycle N.
REQ-028 SHALL accept back-to-back reads every cycle; AVL_READDATA is 0 whenever AVL_READDATAVALID=0.
REQ-029 SHALL treat simultaneous AVL_READ and AVL_WRITE as a write only, with no readdatavalid.

Reset
REQ-030 SHALL, on RESET high at a clock edge, clear ACC, LEDREG, STATUS, LED, AVL_READDATA, AVL_READDATAVALID and the sync flops, set both FSMs to IDLE and zero the counters.
REQ-031 SHALL, on reset mid-debounce or mid-read, abandon the pending press and drop the in-flight readdatavalid; a key held low through reset produces a press only after a full DEBOUNCE_CYCLES from reset release.

Structure
REQ-032 SHALL place the register address constants (ADDR_SW, ADDR_ACC, ADDR_LED, ADDR_STATUS), STATUS bit indices and the key FSM state enum in package avl_accum_pkg.
REQ-033 SHALL implement sync, debounce and pulse generation in one sub-module, key_debounce, instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 SHALL cover accumulate with wrap: SW=0x30, three accumulate presses held 10 cycles each -> ACC=0x90, OVF=0; a fourth press with SW=0x80 -> ACC=0x10, OVF=1, PEND=1.
REQ-035 SHALL cover debounce: KEY_ACCUM_N low for 3 cycles, bouncing, then low for 20 cycles -> exactly one pulse, ACC increments once.
REQ-036 SHALL cover read latency: reads to addresses 1, 2, 3 on consecutive cycles -> READDATAVALID high for 3 cycles starting 1 cycle later, data in order.
REQ-037 SHALL cover collisions: an Avalon write ACC=0x55 in the same cycle as an accumulate pulse -> ACC=0x55, PEND=1; W1C of PEND colliding with a new pulse -> PEND=1.
REQ-038 SHALL cover LED source: write LEDREG=0xA5 with LEDSRC=0 -> LED=0xA5; set LEDSRC=1 with ACC=0x3C -> LED=0x3C one cycle later.
REQ-039 SHALL cover reset mid-debounce: assert RESET at debounce count 2 with the key held low -> no pulse, ACC=0, and a pulse only 4+ cycles after release of RESET.
